// File: rtl/led_pattern_gen_pkg.sv
// Shared constants for the board-demo LED pattern generator: display modes,
// the switch-indexed step-interval table and interval counter width.
package led_pkg;

  localparam int MODE_W     = 2;
  localparam int ICNT_W     = 12;
  localparam int RATE_IDX_W = 4;
  localparam int N_RATE_TAB = 10;

  typedef enum logic [MODE_W-1:0] {
    MODE_ALT    = 2'd0,
    MODE_BLINK  = 2'd1,
    MODE_CHASE  = 2'd2,
    MODE_BOUNCE = 2'd3
  } mode_e;

  // Step interval in ms; element 0 is the rightmost entry.
  localparam logic [N_RATE_TAB-1:0][ICNT_W-1:0] RATE_MS = {
    12'd1000, 12'd750, 12'd500, 12'd250, 12'd125,
    12'd1000, 12'd1500, 12'd2000, 12'd3000, 12'd4000
  };

  function automatic logic [ICNT_W-1:0] rate_ms(input logic [RATE_IDX_W-1:0] idx);
    logic [ICNT_W-1:0] r;
    r = RATE_MS[0];
    for (int i = 0; i < N_RATE_TAB; i++)
      if (idx == RATE_IDX_W'(i)) r = RATE_MS[i];
    return r;
  endfunction

endpackage

// File: rtl/led_pattern_gen_if.sv
// Switch/LED bundle for one LED bank: the board side drives switches and mode,
// the pattern generator drives the LEDs and the step pulse.
interface led_pattern_gen_if
  import led_pkg::*;
#(
  parameter int N_LEDS  = 10,
  parameter int N_RATES = 10
);
  logic [N_RATES-1:0] SW;
  logic [MODE_W-1:0]  MODE;
  logic [N_LEDS-1:0]  LEDS;
  logic               STEP;

  modport master (output SW, output MODE, input LEDS, input STEP);
  modport slave  (input SW, input MODE, output LEDS, output STEP);
endinterface

// File: rtl/led_pattern_gen_tick_gen.sv
// Free-running prescaler producing a one-cycle tick every TICK_DIV clocks.
module tick_gen #(
  parameter int TICK_DIV = 50000
) (
  input  logic CLOCK_50,
  input  logic RESET,
  output logic tick
);
  localparam int PW = $clog2(TICK_DIV);

  logic [PW-1:0] pcnt_q, pcnt_d;

  always_comb begin
    tick   = (pcnt_q == PW'(TICK_DIV - 1));
    pcnt_d = tick ? '0 : pcnt_q + PW'(1);
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) pcnt_q <= '0;
    else       pcnt_q <= pcnt_d;
  end
endmodule

// File: rtl/led_pattern_gen.sv
// LED pattern generator: switch-selected step rate, four display modes
// (alternate, all-blink, chase, bounce) decoded from shared step state.
module led_pattern_gen
  import led_pkg::*;
#(
  parameter int N_LEDS   = 10,
  parameter int N_RATES  = 10,
  parameter int TICK_DIV = 50000
) (
  input  logic        CLOCK_50,
  input  logic        RESET,
  led_pattern_gen_if.slave bus
);
  localparam int PW = $clog2(N_LEDS);

  logic                  tick;
  logic [RATE_IDX_W-1:0] sel_idx, sel_prev_q, sel_prev_d;
  logic                  paused, rate_chg, advance;
  logic [ICNT_W-1:0]     interval, icnt_q, icnt_d;
  logic                  phase_q, phase_d, dir_q, dir_d, step_q, step_d;
  logic [PW-1:0]         pos_q, pos_d, cpos_q, cpos_d;
  logic [N_LEDS-1:0]     leds;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .CLOCK_50 (CLOCK_50),
    .RESET    (RESET),
    .tick     (tick)
  );

  // Lowest-index set switch wins; no switch set means paused.
  always_comb begin
    sel_idx = '0;
    for (int i = N_RATES - 1; i >= 0; i--)
      if (bus.SW[i]) sel_idx = RATE_IDX_W'(i);
    paused   = ~|bus.SW;
    rate_chg = !paused && (sel_idx != sel_prev_q);
    interval = rate_ms(sel_idx);
  end

  // A rate change restarts the interval and swallows any coincident tick;
  // pausing freezes the count so a resume picks up where it left off.
  always_comb begin
    icnt_d     = icnt_q;
    advance    = 1'b0;
    sel_prev_d = paused ? sel_prev_q : sel_idx;
    if (!paused) begin
      if (rate_chg) begin
        icnt_d = '0;
      end else if (tick) begin
        if (icnt_q == interval - ICNT_W'(1)) begin
          icnt_d  = '0;
          advance = 1'b1;
        end else begin
          icnt_d = icnt_q + ICNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    phase_d = phase_q;
    pos_d   = pos_q;
    dir_d   = dir_q;
    cpos_d  = cpos_q;
    step_d  = advance;
    if (advance) begin
      phase_d = ~phase_q;
      cpos_d  = (cpos_q == PW'(N_LEDS - 1)) ? '0 : cpos_q + PW'(1);
      if (!dir_q) begin
        if (pos_q == PW'(N_LEDS - 1)) begin
          dir_d = 1'b1;
          pos_d = pos_q - PW'(1);
        end else begin
          pos_d = pos_q + PW'(1);
        end
      end else begin
        if (pos_q == '0) begin
          dir_d = 1'b0;
          pos_d = pos_q + PW'(1);
        end else begin
          pos_d = pos_q - PW'(1);
        end
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      icnt_q     <= '0;
      sel_prev_q <= sel_idx;
      phase_q    <= 1'b0;
      pos_q      <= '0;
      dir_q      <= 1'b0;
      cpos_q     <= '0;
      step_q     <= 1'b0;
    end else begin
      icnt_q     <= icnt_d;
      sel_prev_q <= sel_prev_d;
      phase_q    <= phase_d;
      pos_q      <= pos_d;
      dir_q      <= dir_d;
      cpos_q     <= cpos_d;
      step_q     <= step_d;
    end
  end

  always_comb begin
    leds = '0;
    case (mode_e'(bus.MODE))
      MODE_ALT:    for (int i = 0; i < N_LEDS; i++) leds[i] = phase_q ^ (i % 2 == 1);
      MODE_BLINK:  leds = {N_LEDS{phase_q}};
      MODE_CHASE:  for (int i = 0; i < N_LEDS; i++) leds[i] = (cpos_q == PW'(i));
      MODE_BOUNCE: for (int i = 0; i < N_LEDS; i++) leds[i] = (pos_q == PW'(i));
      default:     leds = '0;
    endcase
  end

  assign bus.LEDS = leds;
  assign bus.STEP = step_q;
endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed + randomized bench for led_pattern_gen against a step-count model.
module tb_led_pattern_gen;
  localparam int NL = 10;
  localparam int NR = 10;
  localparam int TD = 2;

  logic CLOCK_50 = 1'b0;
  logic RESET;
  always #5 CLOCK_50 = ~CLOCK_50;

  led_pattern_gen_if #(.N_LEDS(NL), .N_RATES(NR)) bus ();

  led_pattern_gen #(.N_LEDS(NL), .N_RATES(NR), .TICK_DIV(TD)) dut (
    .CLOCK_50 (CLOCK_50),
    .RESET    (RESET),
    .bus      (bus)
  );

  int rate_tab [10] = '{4000, 3000, 2000, 1500, 1000, 125, 250, 500, 750, 1000};

  // Model: pattern is a pure function of how many steps have elapsed (k).
  int n_tests = 0, n_fail = 0;
  int cyc = 0, edges = 0, ms_elapsed = 0, k = 0, prev_sel = 0;
  bit step_exp = 0;

  function automatic int sel_of(input logic [NR-1:0] sw);
    for (int i = 0; i < NR; i++) if (sw[i]) return i;
    return 0;
  endfunction

  function automatic logic [NL-1:0] exp_leds(input int steps, input logic [1:0] mode);
    logic [NL-1:0] r;
    int m, p;
    r = '0;
    case (mode)
      2'd0: for (int i = 0; i < NL; i++) r[i] = ((steps % 2) != (i % 2));
      2'd1: r = (steps % 2 == 1) ? '1 : '0;
      2'd2: r[steps % NL] = 1'b1;
      default: begin
        m = steps % (2 * NL - 2);
        p = (m < NL) ? m : (2 * NL - 2 - m);
        r[p] = 1'b1;
      end
    endcase
    return r;
  endfunction

  task automatic check(input string tag, input logic [NL-1:0] got, input logic [NL-1:0] want);
    n_tests++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, got, want);
    end
  endtask

  task automatic step_cycle();
    @(posedge CLOCK_50);
    cyc++;
    if (RESET) begin
      edges = 0; ms_elapsed = 0; k = 0; step_exp = 0; prev_sel = sel_of(bus.SW);
    end else begin
      edges++;
      step_exp = 0;
      if (bus.SW != '0) begin
        if (sel_of(bus.SW) != prev_sel) begin
          prev_sel = sel_of(bus.SW);
          ms_elapsed = 0;
        end else if (edges % TD == 0) begin
          ms_elapsed++;
          if (ms_elapsed == rate_tab[prev_sel]) begin
            ms_elapsed = 0;
            k++;
            step_exp = 1;
          end
        end
      end
    end
    #1;
    check("leds", bus.LEDS, exp_leds(k, bus.MODE));
    check("step", NL'(bus.STEP), NL'(step_exp));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step_cycle();
  endtask

  initial begin
    int seg;
    int lim;
    RESET = 1'b1;
    bus.SW = 10'h020;
    bus.MODE = 2'd0;
    run(2);
    // Reset-state decode in every mode, combinational on MODE.
    bus.MODE = 2'd0; #1; check("rst_m0", bus.LEDS, 10'h2AA);
    bus.MODE = 2'd1; #1; check("rst_m1", bus.LEDS, 10'h000);
    bus.MODE = 2'd2; #1; check("rst_m2", bus.LEDS, 10'h001);
    bus.MODE = 2'd3; #1; check("rst_m3", bus.LEDS, 10'h001);
    bus.MODE = 2'd0;
    run(1);
    RESET = 1'b0;

    // First advance lands exactly on edge TICK_DIV*125 = 250.
    run(249);
    check("pre_first", bus.LEDS, 10'h2AA);
    check("pre_step", NL'(bus.STEP), NL'(0));
    run(1);
    check("first_adv", bus.LEDS, 10'h155);
    check("first_step", NL'(bus.STEP), NL'(1));
    run(1);
    check("step_once", NL'(bus.STEP), NL'(0));

    // Switch 0 wins over switch 5; dropping it restarts the count.
    bus.SW = 10'h021;
    run(1000 + $urandom_range(0, 99));
    bus.SW = 10'h020;
    run(600);

    bus.MODE = 2'd3;
    run(20 * 250 + 10);
    bus.MODE = 2'd2;
    run(10 * 250 + 10);

    // Pause then resume: count continues from its held value.
    run($urandom_range(50, 200));
    bus.SW = '0;
    run(10000);
    bus.SW = 10'h020;
    run(600);

    // Randomized rates/modes/pauses on the faster switches.
    for (int s = 0; s < 16; s++) begin
      bus.SW = NR'($urandom & 32'h3E0);
      if ($urandom_range(0, 5) == 0) bus.SW = '0;
      bus.MODE = 2'($urandom_range(0, 3));
      seg = $urandom_range(100, 900);
      run(seg);
    end

    // Reset while bouncing back down through pos 6.
    bus.SW = 10'h020;
    bus.MODE = 2'd3;
    lim = 0;
    while (!(step_exp && (k % (2 * NL - 2) == 12)) && lim < 20000) begin
      step_cycle();
      lim++;
    end
    check("reach_pos6", NL'(lim < 20000), NL'(1));
    check("pos6_leds", bus.LEDS, 10'h040);
    RESET = 1'b1;
    run(1);
    check("rst_bounce", bus.LEDS, 10'h001);
    check("rst_step", NL'(bus.STEP), NL'(0));
    RESET = 1'b0;
    run(300);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
